// File: rtl/ara_pkg.sv
// Shared ARA accelerator types: collector op codes, writeback drain states
// and the default writeback beat width.
package ara_pkg;

  typedef enum logic [1:0] {
    NOP,
    READ,
    WRITE,
    ACCUM
  } accel_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CLEAR
  } wb_state_e;

  localparam int WB_BEAT_WORDS = 4;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/for_writeback_penc.sv
// Lowest-set-bit priority encoder used to pick the next result register to drain.
module for_writeback_penc import ara_pkg::*; #(
  parameter int N  = 8,
  parameter int IW = idxWidth(N)
) (
  input  logic [N-1:0]  mask_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = IW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/for_writeback.sv
// Drains the valid result registers of the output collector to the vector
// register file as BEAT_WORDS-wide beats, lowest register index first.
module for_writeback import ara_pkg::*; #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int DATA_OF_SET = 128,
  parameter  int NUM_OF_RES  = 8,
  parameter  int BEAT_WORDS  = WB_BEAT_WORDS,
  localparam int NUM_BEATS   = DATA_OF_SET / BEAT_WORDS,
  localparam int RIDX_W      = idxWidth(NUM_OF_RES),
  localparam int BIDX_W      = idxWidth(NUM_BEATS),
  localparam int WIDX_W      = idxWidth(DATA_OF_SET)
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 start,
  input  logic [NUM_OF_RES-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] res,
  input  logic [NUM_OF_RES-1:0]                                res_valid,
  input  logic                                                 full_flag,
  output logic                                                 wb_valid,
  input  logic                                                 wb_ready,
  output logic [BEAT_WORDS-1:0][DATA_WIDTH-1:0]                wb_data,
  output logic [RIDX_W-1:0]                                    wb_reg_idx,
  output logic [BIDX_W-1:0]                                    wb_beat_idx,
  output logic                                                 wb_last,
  output logic                                                 hold,
  output logic                                                 clr,
  output logic                                                 done
);

  wb_state_e             state_q, state_d;
  logic [NUM_OF_RES-1:0] mask_q, mask_d;
  logic [BIDX_W-1:0]     beat_q, beat_d;

  logic [RIDX_W-1:0]     curIdx;
  logic                  anySet;
  logic [NUM_OF_RES-1:0] curBit;
  logic [NUM_OF_RES-1:0] maskRest;
  logic                  finalBeat;
  logic                  lastReg;
  logic                  handshake;

  for_writeback_penc #(
    .N  (NUM_OF_RES),
    .IW (RIDX_W)
  ) u_penc (
    .mask_i (mask_q),
    .idx_o  (curIdx),
    .any_o  (anySet)
  );

  assign curBit    = NUM_OF_RES'(1) << curIdx;
  assign maskRest  = mask_q & ~curBit;
  assign finalBeat = (beat_q == BIDX_W'(NUM_BEATS - 1));
  assign lastReg   = (maskRest == '0);
  assign handshake = wb_valid && wb_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      beat_q  <= beat_d;
    end
  end

  // The mask and beat counter only move on a handshake, which keeps the
  // presented beat stable for as long as the sink stalls.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (start || full_flag) begin
          mask_d  = res_valid;
          beat_d  = '0;
          state_d = (res_valid == '0) ? CLEAR : SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (finalBeat) begin
            beat_d = '0;
            mask_d = maskRest;
            if (lastReg) begin
              state_d = CLEAR;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Payload is read straight from the collector; hold keeps res frozen while draining.
  always_comb begin
    wb_valid    = 1'b0;
    wb_last     = 1'b0;
    wb_reg_idx  = '0;
    wb_beat_idx = '0;
    wb_data     = '0;
    hold        = (state_q != IDLE);
    clr         = (state_q == CLEAR);
    done        = (state_q == CLEAR);
    if (state_q == SEND && anySet) begin
      wb_valid    = 1'b1;
      wb_reg_idx  = curIdx;
      wb_beat_idx = beat_q;
      wb_last     = finalBeat && lastReg;
      for (int w = 0; w < BEAT_WORDS; w++) begin
        wb_data[w] = res[curIdx][WIDX_W'(int'(beat_q) * BEAT_WORDS + w)];
      end
    end
  end

endmodule

// File: tb/tb_for_writeback.sv
// Self-checking bench for for_writeback: vector table, reset/priority corner
// sequences and randomized drains against a per-beat expectation queue.
`timescale 1ns/1ps
module tb_for_writeback;

  localparam int DW     = 32;
  localparam int DOS    = 128;
  localparam int NRES   = 8;
  localparam int BW     = 4;
  localparam int NBEATS = DOS / BW;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            start;
  logic                            full_flag;
  logic                            wb_ready;
  logic [NRES-1:0][DOS-1:0][DW-1:0] resArr;
  logic [NRES-1:0]                 res_valid;
  logic                            wb_valid;
  logic                            wb_last;
  logic                            hold;
  logic                            clr;
  logic                            done;
  logic [BW-1:0][DW-1:0]           wb_data;
  logic [2:0]                      wb_reg_idx;
  logic [4:0]                      wb_beat_idx;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int               regIdx;
    int               beatIdx;
    bit               last;
    logic [BW*DW-1:0] data;
  } beat_t;

  typedef struct {
    logic [NRES-1:0] mask;
    bit              viaFull;
    int              readyMode;
    int              repulseAt;
    int              expBeats;
  } vec_t;

  beat_t expQ[$];
  vec_t  vecs[7];

  always #5 clk = ~clk;

  for_writeback #(
    .DATA_WIDTH  (DW),
    .DATA_OF_SET (DOS),
    .NUM_OF_RES  (NRES),
    .BEAT_WORDS  (BW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .res         (resArr),
    .res_valid   (res_valid),
    .full_flag   (full_flag),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_reg_idx  (wb_reg_idx),
    .wb_beat_idx (wb_beat_idx),
    .wb_last     (wb_last),
    .hold        (hold),
    .clr         (clr),
    .done        (done)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [12:0] ctrlNow();
    return {wb_valid, wb_reg_idx, wb_beat_idx, wb_last, hold, clr, done};
  endfunction

  function automatic logic [12:0] ctrlExp(input bit v, input int r, input int b, input bit l,
                                          input bit h, input bit c, input bit d);
    return {v, 3'(r), 5'(b), l, h, c, d};
  endfunction

  function automatic logic pickReady(input int mode, input int cyc);
    if (mode == 1) return logic'(cyc % 2 == 0);
    if (mode == 2) return logic'($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  task automatic fillRes();
    for (int r = 0; r < NRES; r++)
      for (int i = 0; i < DOS; i++)
        resArr[r][i] = $urandom();
  endtask

  // Expected drain: every set register in ascending order, all beats, last flag on the final one.
  task automatic buildModel(input logic [NRES-1:0] mask);
    beat_t e;
    expQ.delete();
    for (int r = 0; r < NRES; r++) begin
      if (mask[r]) begin
        for (int b = 0; b < NBEATS; b++) begin
          e.regIdx  = r;
          e.beatIdx = b;
          e.last    = 1'b0;
          e.data    = '0;
          for (int w = 0; w < BW; w++) e.data[w*DW +: DW] = resArr[r][b*BW + w];
          expQ.push_back(e);
        end
      end
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_back();
      e.last = 1'b1;
      expQ.push_back(e);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " ctrl"}, 128'(ctrlNow()), 128'(ctrlExp(0, 0, 0, 0, 0, 0, 0)));
    checkOutput({name, " data"}, 128'(wb_data), 128'(0));
  endtask

  task automatic applyStimulus(input vec_t v, output int accepted);
    bit finished;
    accepted = 0;
    finished = 1'b0;
    fillRes();
    buildModel(v.mask);
    @(posedge clk); #1;
    res_valid = v.mask;
    if (v.viaFull) full_flag = 1'b1;
    else           start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    full_flag = 1'b0;
    wb_ready  = pickReady(v.readyMode, 0);
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        checkOutput("beat ctrl", 128'(ctrlNow()),
                    128'(ctrlExp(1, expQ[0].regIdx, expQ[0].beatIdx, expQ[0].last, 1, 0, 0)));
        checkOutput("beat data", 128'(wb_data), expQ[0].data);
        if (wb_ready) begin
          void'(expQ.pop_front());
          accepted++;
        end
      end else begin
        checkOutput("clear pulse", 128'(ctrlNow()), 128'(ctrlExp(0, 0, 0, 0, 1, 1, 1)));
        finished = 1'b1;
      end
      @(posedge clk); #1;
      wb_ready = pickReady(v.readyMode, cyc + 1);
      start    = (cyc + 1 == v.repulseAt) && (expQ.size() > 1);
    end
    start = 1'b0;
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain timeout: %0d beats outstanding, required 0", expQ.size());
    end
    @(negedge clk);
    checkIdle("post drain");
  endtask

  initial begin
    vec_t v;
    int   accepted;
    bit   seen;

    rst       = 1'b1;
    start     = 1'b0;
    full_flag = 1'b0;
    wb_ready  = 1'b0;
    res_valid = '0;
    fillRes();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    vecs[0] = '{8'h01, 1'b0, 0, -1, 32};
    vecs[1] = '{8'hFF, 1'b1, 0, -1, 256};
    vecs[2] = '{8'hA1, 1'b0, 1, -1, 96};
    vecs[3] = '{8'h00, 1'b0, 0, -1, 0};
    vecs[4] = '{8'h12, 1'b0, 2, 5, 64};
    vecs[5] = '{8'h80, 1'b1, 1, 40, 32};
    vecs[6] = '{8'h5A, 1'b0, 0, 70, 128};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], accepted);
      checkOutput($sformatf("vec%0d beats", i), 128'(accepted), 128'(vecs[i].expBeats));
    end

    // Reset in the middle of register 3, beat 10: abort with no clear pulse.
    fillRes();
    @(posedge clk); #1;
    res_valid = 8'h18;
    start     = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    wb_ready = 1'b1;
    seen     = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (wb_valid && wb_reg_idx == 3'd3 && wb_beat_idx == 5'd9) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL reach reg3 beat9: not seen within 200 cycles");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("pre-reset position", 128'({wb_valid, wb_reg_idx, wb_beat_idx}), 128'({1'b1, 3'd3, 5'd10}));
    @(negedge clk);
    checkIdle("mid-drain reset");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkIdle("after abort");
    end
    v = '{8'h18, 1'b0, 0, -1, 64};
    applyStimulus(v, accepted);
    checkOutput("restart beats", 128'(accepted), 128'(64));

    // Reset wins over a simultaneous start.
    @(posedge clk); #1;
    rst       = 1'b1;
    start     = 1'b1;
    full_flag = 1'b1;
    res_valid = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    checkIdle("rst over start");
    @(posedge clk); #1;
    rst       = 1'b0;
    start     = 1'b0;
    full_flag = 1'b0;
    @(negedge clk);
    checkIdle("rst over start after");

    for (int i = 0; i < 6; i++) begin
      v.mask      = 8'($urandom_range(0, 255));
      v.viaFull   = 1'($urandom_range(0, 1));
      v.readyMode = int'($urandom_range(0, 2));
      v.repulseAt = int'($urandom_range(1, 60));
      v.expBeats  = $countones(v.mask) * NBEATS;
      applyStimulus(v, accepted);
      checkOutput($sformatf("rand%0d beats mask %0h", i, v.mask), 128'(accepted), 128'(v.expBeats));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
